// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums every LEN accepted products into one flagged ready/valid result
module product_accumulator #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int LEN       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 i_ready,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_payload,
    input  logic                 o_ready,
    output logic                 o_valid,
    output logic [ACC_WIDTH-1:0] o_payload,
    output logic                 o_overflow
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] pay_q, pay_d;
    logic                 oflag_q, oflag_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 accept;

    always_comb begin
        sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, i_payload};
        accept  = (state_q == ST_ACCUM) && i_valid;
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        pay_d   = pay_q;
        oflag_d = oflag_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        // Final product of the group: publish and restart the group.
                        pay_d   = sum[ACC_WIDTH-1:0];
                        oflag_d = ovf_q | sum[ACC_WIDTH];
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                        cnt_d = cnt_q + 1'b1;
                        ovf_d = ovf_q | sum[ACC_WIDTH];
                    end
                end
            end
            ST_HOLD: begin
                if (o_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pay_q   <= '0;
            oflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pay_q   <= pay_d;
            oflag_q <= oflag_d;
        end
    end

    // Held low during reset so upstream never sees a transfer while state is being cleared.
    assign i_ready    = (state_q == ST_ACCUM) && !reset;
    assign o_valid    = (state_q == ST_HOLD);
    assign o_payload  = pay_q;
    assign o_overflow = oflag_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  i_valid_v = '0;
    logic [2:0]  o_ready_v = 3'b111;
    logic [2:0]  i_ready_v;
    logic [2:0]  o_valid_v;
    logic [2:0]  o_ovf_v;
    logic [31:0] i_pay_v [3];
    logic [63:0] o_pay_v [3];
    logic [39:0] o_pay0;
    logic [32:0] o_pay1;
    logic [39:0] o_pay2;

    int checks = 0;
    int errors = 0;
    int last_wait = 0;

    // Instance 0: defaults; instance 1: 33-bit accumulator; instance 2: LEN=1.
    int accw [3] = '{40, 33, 40};
    int lenv [3] = '{4, 4, 1};

    always #5 clk = ~clk;

    product_accumulator #(.IN_WIDTH(32), .ACC_WIDTH(40), .LEN(4)) u_dut0 (
        .clk(clk), .reset(reset), .i_ready(i_ready_v[0]), .i_valid(i_valid_v[0]),
        .i_payload(i_pay_v[0]), .o_ready(o_ready_v[0]), .o_valid(o_valid_v[0]),
        .o_payload(o_pay0), .o_overflow(o_ovf_v[0])
    );
    product_accumulator #(.IN_WIDTH(32), .ACC_WIDTH(33), .LEN(4)) u_dut1 (
        .clk(clk), .reset(reset), .i_ready(i_ready_v[1]), .i_valid(i_valid_v[1]),
        .i_payload(i_pay_v[1]), .o_ready(o_ready_v[1]), .o_valid(o_valid_v[1]),
        .o_payload(o_pay1), .o_overflow(o_ovf_v[1])
    );
    product_accumulator #(.IN_WIDTH(32), .ACC_WIDTH(40), .LEN(1)) u_dut2 (
        .clk(clk), .reset(reset), .i_ready(i_ready_v[2]), .i_valid(i_valid_v[2]),
        .i_payload(i_pay_v[2]), .o_ready(o_ready_v[2]), .o_valid(o_valid_v[2]),
        .o_payload(o_pay2), .o_overflow(o_ovf_v[2])
    );

    assign o_pay_v[0] = 64'(o_pay0);
    assign o_pay_v[1] = 64'(o_pay1);
    assign o_pay_v[2] = 64'(o_pay2);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: true group sum in 64 bits, reduced modulo 2^ACC_WIDTH only when published.
    logic        m_hold [3];
    logic [63:0] m_sum  [3];
    int          m_cnt  [3];
    logic [63:0] m_pay  [3];
    logic        m_ovf  [3];

    initial begin
        logic        s_rst;
        logic [2:0]  s_iv;
        logic [2:0]  s_or;
        logic [31:0] s_pay [3];
        for (int k = 0; k < 3; k++) begin
            m_hold[k] = 1'b0; m_sum[k] = '0; m_cnt[k] = 0; m_pay[k] = '0; m_ovf[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            s_rst = reset;
            s_iv  = i_valid_v;
            s_or  = o_ready_v;
            for (int k = 0; k < 3; k++) s_pay[k] = i_pay_v[k];
            #1;
            for (int k = 0; k < 3; k++) begin
                if (s_rst) begin
                    m_hold[k] = 1'b0; m_sum[k] = '0; m_cnt[k] = 0; m_pay[k] = '0; m_ovf[k] = 1'b0;
                end else if (!m_hold[k]) begin
                    if (s_iv[k]) begin
                        m_sum[k] = m_sum[k] + 64'(s_pay[k]);
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == lenv[k]) begin
                            m_pay[k]  = m_sum[k] & ((64'd1 << accw[k]) - 64'd1);
                            m_ovf[k]  = (m_sum[k] >> accw[k]) != 64'd0;
                            m_hold[k] = 1'b1;
                            m_sum[k]  = '0;
                            m_cnt[k]  = 0;
                        end
                    end
                end else if (s_or[k]) begin
                    m_hold[k] = 1'b0;
                end
                chk($sformatf("inst%0d_i_ready", k), 64'(i_ready_v[k]), 64'(!m_hold[k] && !reset));
                chk($sformatf("inst%0d_o_valid", k), 64'(o_valid_v[k]), 64'(m_hold[k]));
                chk($sformatf("inst%0d_o_payload", k), o_pay_v[k], m_pay[k]);
                chk($sformatf("inst%0d_o_overflow", k), 64'(o_ovf_v[k]), 64'(m_ovf[k]));
            end
        end
    end

    // Presents v from a falling edge and returns just after the rising edge that takes it.
    task automatic send(input int k, input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        i_valid_v[k] = 1'b1;
        i_pay_v[k]   = v;
        while (!i_ready_v[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst%0d: i_ready stayed %0b, required 1", k, i_ready_v[k]);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid_v = '0;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) i_pay_v[k] = '0;
        repeat (2) @(negedge clk);
        chk("rst_i_ready", 64'(i_ready_v[0]), 64'd0);
        chk("rst_o_valid", 64'(o_valid_v[0]), 64'd0);
        chk("rst_o_payload", o_pay_v[0], 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_i_ready", 64'(i_ready_v[0]), 64'd1);

        // Basic back-to-back group
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        chk("basic_wait", 64'(last_wait), 64'd0);
        #1;
        chk("basic_o_valid", 64'(o_valid_v[0]), 64'd1);
        chk("basic_o_payload", o_pay_v[0], 64'd10);
        chk("basic_o_overflow", 64'(o_ovf_v[0]), 64'd0);
        chk("basic_i_ready_hold", 64'(i_ready_v[0]), 64'd0);
        @(posedge clk); #1;
        chk("basic_i_ready_after", 64'(i_ready_v[0]), 64'd1);
        chk("basic_o_valid_after", 64'(o_valid_v[0]), 64'd0);
        idle(2);

        // Backpressure: offered 7 must wait out the held result
        o_ready_v[0] = 1'b0;
        send(0, 2); send(0, 3); send(0, 1); send(0, 4);
        repeat (5) begin
            @(negedge clk);
            i_valid_v[0] = 1'b1;
            i_pay_v[0]   = 7;
            chk("bp_hold_payload", o_pay_v[0], 64'd10);
            chk("bp_i_ready", 64'(i_ready_v[0]), 64'd0);
            chk("bp_o_valid", 64'(o_valid_v[0]), 64'd1);
        end
        @(negedge clk);
        o_ready_v[0] = 1'b1;
        send(0, 7); send(0, 1); send(0, 1); send(0, 1);
        #1;
        chk("bp_next_payload", o_pay_v[0], 64'd10);
        idle(2);

        // Gaps inside a group
        send(0, 5);
        idle(3);
        send(0, 6); send(0, 7); send(0, 8);
        #1;
        chk("gap_payload", o_pay_v[0], 64'd26);
        chk("gap_o_valid", 64'(o_valid_v[0]), 64'd1);
        idle(2);

        // Mid-group reset discards the partial sum
        send(0, 100); send(0, 200);
        @(negedge clk);
        i_valid_v = '0;
        reset = 1'b1;
        #1;
        chk("mid_rst_i_ready", 64'(i_ready_v[0]), 64'd0);
        @(negedge clk);
        chk("mid_rst_o_valid", 64'(o_valid_v[0]), 64'd0);
        chk("mid_rst_i_ready2", 64'(i_ready_v[0]), 64'd0);
        reset = 1'b0;
        send(0, 1); send(0, 1); send(0, 1); send(0, 1);
        #1;
        chk("mid_rst_payload", o_pay_v[0], 64'd4);
        idle(2);

        // Wide accumulator absorbs the sum of maximal products
        send(0, 32'hFFFF_FFFF); send(0, 32'hFFFF_FFFF); send(0, 32'hFFFF_FFFF); send(0, 32'hFFFF_FFFF);
        #1;
        chk("wide_payload", o_pay_v[0], 64'h3_FFFF_FFFC);
        chk("wide_overflow", 64'(o_ovf_v[0]), 64'd0);
        idle(2);

        // 33-bit accumulator overflow, then a clean group
        send(1, 32'hFFFF_FFFF); send(1, 32'hFFFF_FFFF); send(1, 32'hFFFF_FFFF); send(1, 32'hFFFF_FFFF);
        #1;
        chk("ovf_payload", o_pay_v[1], 64'h1_FFFF_FFFC);
        chk("ovf_flag", 64'(o_ovf_v[1]), 64'd1);
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        #1;
        chk("ovf_next_payload", o_pay_v[1], 64'd4);
        chk("ovf_next_flag", 64'(o_ovf_v[1]), 64'd0);
        idle(2);

        // LEN=1 pass-through, one bubble between results
        send(2, 32'hDEAD_BEEF);
        #1;
        chk("len1_first", o_pay_v[2], 64'hDE_ADBE_EF);
        chk("len1_first_ovf", 64'(o_ovf_v[2]), 64'd0);
        send(2, 0);
        chk("len1_bubble", 64'(last_wait), 64'd1);
        #1;
        chk("len1_second", o_pay_v[2], 64'd0);
        chk("len1_second_valid", 64'(o_valid_v[2]), 64'd1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
